hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 32-bit in-order core. It sits beside the decode stage.
- Keeps a per-register scoreboard of writes that have issued but are not yet visible. Stalls decode on read-after-write hazards against that scoreboard.
- Sequences the decode-stage flush after a taken branch resolves in execute, and squashes scoreboard entries of wrong-path instructions.
- Drives the flush input of decode and the hold/enable of the fetch and decode pipeline registers.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- WB_LAT, 3, cycles from the issue edge until the written value is readable from the register file; legal range 1..7.
- FLUSH_CYC, 2, number of cycles flush is asserted per taken branch; legal range 1..7.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, synchronous, active-low.
- id_valid, input, 1, decode holds a valid instruction.
- id_rs1, input, 5, source register 1 (instr[19:15]).
- id_rs2, input, 5, source register 2 (instr[14:10]).
- id_rs1_used, input, 1, instruction reads rs1.
- id_rs2_used, input, 1, instruction reads rs2.
- id_rd, input, 5, destination register (instr[24:20]).
- id_write, input, 1, instruction writes rd.
- br_taken, input, 1, branch taken, resolved in execute this cycle.
- stall, output, 1, hold fetch/decode registers.
- flush, output, 1, squash decode output; this is the decode flush input.
- issue, output, 1, instruction leaves decode at this clock edge.
- stall_cnt, output, CNT_W, saturating count of stall cycles.

Behaviour:
- Reset (rst_n=0 at a posedge): all scoreboard counters = 0, flush FSM = IDLE, flush down-counter = 0, stall_cnt = 0. Reset mid-flush or mid-stall aborts it; the first cycle after reset has stall=0 and flush=0.
- Scoreboard: one 3-bit counter sb[r] per register r = 1..NREGS-1. sb[0] is constant 0.
- Hazard (combinational):
  - hz1 = id_rs1_used & (sb[id_rs1] != 0).
  - hz2 = id_rs2_used & (sb[id_rs2] != 0).
  - hazard = id_valid & (hz1 | hz2).
- Outputs (combinational):
  - flush = br_taken | (state == FLUSH).
  - stall = hazard & ~flush.
  - issue = id_valid & ~stall & ~flush.
- Scoreboard update, each posedge, priority order:
  1. If issue & id_write & id_rd != 0: sb[id_rd] = WB_LAT. This overrides any decrement of the same entry (WAW re-arm).
  2. Otherwise, if br_taken & sb[r] == WB_LAT: sb[r] = 0. This squashes the entry of the instruction that issued in the cycle immediately behind the branch.
  3. Otherwise, if sb[r] != 0: sb[r] = sb[r] - 1.
- Self-reference: the hazard check for an instruction uses the counters before its own rd update, so an instruction that reads and writes the same rd does not stall on itself.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH when br_taken and FLUSH_CYC > 1; fcnt = FLUSH_CYC - 1.
  - In FLUSH: fcnt decrements each cycle; FLUSH -> IDLE when fcnt reaches 1 at the edge.
  - br_taken while in FLUSH restarts fcnt = FLUSH_CYC - 1.
  - Result: flush is high for exactly FLUSH_CYC consecutive cycles starting in the br_taken cycle.
- Priority: flush dominates stall. No instruction issues while flush is high.
- stall_cnt increments by 1 at each edge where stall=1 and saturates at all-ones. It is not cleared by flush.
- No combinational path from any output back to any input.

Test Plan:
1. Reset with random inputs held -> next cycle stall=0, flush=0, stall_cnt=0, all sb = 0.
2. RAW stall:
   - Stimulus: issue a write to r5 at edge t0, then the next instruction reads rs1=r5.
   - Required: stall=1 in cycles t1, t2, t3; issue=1 in t4; stall_cnt=3.
   - Repeat with rd=r0 -> no stall.
3. Taken branch:
   - Stimulus: br_taken=1 for one cycle with FLUSH_CYC=2.
   - Required: flush=1 for exactly 2 cycles; issue=0 in both.
   - Also: an instruction writing r9 that issued the cycle before br_taken -> sb[9] = 0 after the edge; a following read of r9 does not stall.
4. Back-to-back branches: br_taken in cycles t and t+1 -> flush high in t..t+2, low in t+3.
5. Simultaneous cases:
   - Instruction reads and writes r7 with sb[7]=0 -> issues without stall.
   - hazard and br_taken in the same cycle -> flush=1, stall=0, stall_cnt unchanged.
6. Saturation and reset:
   - Preload stall_cnt near all-ones, hold a hazard -> count saturates at all-ones.
   - Assert rst_n=0 mid-flush -> flush=0 and stall_cnt=0 the cycle after.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller sitting beside the decode stage.
//
// Tracks, per architectural register, how many cycles remain until an issued
// write becomes readable from the register file. Decode is stalled while an
// instruction reads a register with a pending write. A taken branch resolved
// in execute flushes decode for FLUSH_CYC cycles and squashes the scoreboard
// entry of the wrong-path instruction that issued right behind the branch.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   id_valid     decode holds a valid instruction
//   id_rs1/rs2   source register numbers
//   id_rs1_used  instruction reads rs1
//   id_rs2_used  instruction reads rs2
//   id_rd        destination register number
//   id_write     instruction writes rd
//   br_taken     branch taken, resolved in execute this cycle
//   stall        hold fetch/decode pipeline registers
//   flush        squash decode output (decode flush input)
//   issue        instruction leaves decode at this clock edge
//   stall_cnt    saturating count of stall cycles
//
// Flush FSM:
//   state | meaning
//   IDLE  | no flush in progress beyond a same-cycle br_taken
//   FLUSH | flush held high; fcnt counts down the remaining cycles

module hazard_ctrl #(
    parameter int NREGS     = 32,
    parameter int WB_LAT    = 3,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_write,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush,
    output logic             issue,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] WB_LAT_C     = 3'(WB_LAT);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYC - 1);

    state_t                  state_q, state_d;
    logic [2:0]              fcnt_q, fcnt_d;
    logic [NREGS-1:0][2:0]   sb_q, sb_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic rs1_busy;
    logic rs2_busy;
    logic hazard;

    // Registers beyond NREGS-1 (only possible when NREGS < 32) never have a
    // pending write, so they are reported idle instead of indexing past sb_q.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if ({27'b0, id_rs1} < NREGS) rs1_busy = (sb_q[id_rs1] != 3'd0);
        if ({27'b0, id_rs2} < NREGS) rs2_busy = (sb_q[id_rs2] != 3'd0);
    end

    // Hazard uses the counters before this instruction's own rd update, so an
    // instruction that reads and writes the same register never self-stalls.
    assign hazard    = id_valid & ((id_rs1_used & rs1_busy) | (id_rs2_used & rs2_busy));
    assign flush     = br_taken | (state_q == FLUSH);
    assign stall     = hazard & ~flush;
    assign issue     = id_valid & ~stall & ~flush;
    assign stall_cnt = cnt_q;

    always_comb begin
        sb_d    = sb_q;
        sb_d[0] = 3'd0;
        for (int r = 1; r < NREGS; r++) begin
            if (issue && id_write && (id_rd == 5'(r))) begin
                // Re-arm wins over decrement (WAW to a still-pending register).
                sb_d[r] = WB_LAT_C;
            end else if (br_taken && (sb_q[r] == WB_LAT_C)) begin
                // A counter still at WB_LAT belongs to the instruction that
                // issued in the cycle directly behind the branch: wrong path.
                sb_d[r] = 3'd0;
            end else if (sb_q[r] != 3'd0) begin
                sb_d[r] = sb_q[r] - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (br_taken && (FLUSH_CYC > 1)) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end
            end
            FLUSH: begin
                if (br_taken) begin
                    fcnt_d = FLUSH_RELOAD;
                end else if (fcnt_q <= 3'd1) begin
                    state_d = IDLE;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= 3'd0;
            sb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int NREGS     = 32;
    localparam int WB_LAT    = 3;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 5;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_rs1_used, id_rs2_used, id_write, br_taken;
    logic             stall, flush, issue;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(
        .NREGS    (NREGS),
        .WB_LAT   (WB_LAT),
        .FLUSH_CYC(FLUSH_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_rd      (id_rd),
        .id_write   (id_write),
        .br_taken   (br_taken),
        .stall      (stall),
        .flush      (flush),
        .issue      (issue),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int fl;
        int is;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_sb[NREGS];
    int m_fl;
    int m_fcnt;
    int m_cnt;

    // last observed DUT outputs
    int o_st, o_fl, o_is, o_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_sb[r] = 0;
        m_fl   = 0;
        m_fcnt = 0;
        m_cnt  = 0;
    endtask

    // One clock cycle: drive inputs, predict outputs, compare at negedge,
    // then advance the model on the posedge.
    task automatic step(input bit rn, input bit v, input int rs1, input bit u1,
                        input int rs2, input bit u2, input int rd, input bit w,
                        input bit br, input bit cmp);
        int   hz, e_fl, e_st, e_is;
        exp_t e, got;
        rst_n       = rn;
        id_valid    = v;
        id_rs1      = 5'(rs1);
        id_rs2      = 5'(rs2);
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = 5'(rd);
        id_write    = w;
        br_taken    = br;
        hz   = (v && ((u1 && m_sb[rs1] != 0) || (u2 && m_sb[rs2] != 0))) ? 1 : 0;
        e_fl = (br || m_fl != 0) ? 1 : 0;
        e_st = (hz != 0 && e_fl == 0) ? 1 : 0;
        e_is = (v && e_st == 0 && e_fl == 0) ? 1 : 0;
        if (cmp) begin
            e.st = e_st; e.fl = e_fl; e.is = e_is; e.cnt = m_cnt;
            exp_q.push_back(e);
        end
        @(negedge clk);
        o_st = int'(stall); o_fl = int'(flush); o_is = int'(issue); o_cnt = int'(stall_cnt);
        if (cmp) begin
            got = exp_q.pop_front();
            chk("stall", o_st, got.st);
            chk("flush", o_fl, got.fl);
            chk("issue", o_is, got.is);
            chk("stall_cnt", o_cnt, got.cnt);
        end
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (e_is != 0 && w && rd == r)          m_sb[r] = WB_LAT;
                else if (br && m_sb[r] == WB_LAT)       m_sb[r] = 0;
                else if (m_sb[r] != 0)                  m_sb[r] = m_sb[r] - 1;
            end
            if (m_fl == 0) begin
                if (br && FLUSH_CYC > 1) begin m_fl = 1; m_fcnt = FLUSH_CYC - 1; end
            end else if (br) begin
                m_fcnt = FLUSH_CYC - 1;
            end else if (m_fcnt <= 1) begin
                m_fl = 0; m_fcnt = 0;
            end else begin
                m_fcnt = m_fcnt - 1;
            end
            if (e_st != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic idle(input bit rn);
        step(rn, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic wr(input int rd);
        step(1, 1, 0, 0, 0, 0, rd, 1, 0, 1);
    endtask

    task automatic rd1(input int rs);
        step(1, 1, rs, 1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic raw_seq(input int r);
        wr(r);
        for (int k = 0; k < 8; k++) begin
            rd1(r);
            if (o_is != 0) break;
        end
        chk("raw_seq_issued", o_is, 1);
    endtask

    int cnt0;
    int hold_rs1, hold_rs2, hold_rd;
    bit hold_u1, hold_u2, hold_w, hold_v;

    initial begin
        model_reset();
        rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_write = 1'b0; br_taken = 1'b0;
        #2;

        // 1. reset with random inputs held
        step(0, 1'($urandom), $urandom_range(31), 1'($urandom), $urandom_range(31),
             1'($urandom), $urandom_range(31), 1'($urandom), 1'($urandom), 0);
        step(0, 1'($urandom), $urandom_range(31), 1'($urandom), $urandom_range(31),
             1'($urandom), $urandom_range(31), 1'($urandom), 1'($urandom), 1);
        idle(1);
        chk("rst_stall", o_st, 0);
        chk("rst_flush", o_fl, 0);
        chk("rst_cnt", o_cnt, 0);
        for (int r = 0; r < NREGS; r++) begin
            step(1, 1, r, 1, r, 1, 0, 0, 0, 1);
            chk("rst_sb_clear", o_st, 0);
        end

        // 2. RAW stall on r5
        wr(5);
        rd1(5); chk("raw_t1_stall", o_st, 1);
        rd1(5); chk("raw_t2_stall", o_st, 1);
        rd1(5); chk("raw_t3_stall", o_st, 1);
        rd1(5); chk("raw_t4_issue", o_is, 1);
        chk("raw_t4_stall", o_st, 0);
        chk("raw_cnt", o_cnt, 3);
        wr(0);
        rd1(0); chk("raw_r0_stall", o_st, 0);
        chk("raw_r0_issue", o_is, 1);

        // 3. taken branch, squash of r9 written right behind it
        wr(9);
        step(1, 1, 9, 1, 0, 0, 9, 1, 1, 1);
        chk("br_c0_flush", o_fl, 1);
        chk("br_c0_issue", o_is, 0);
        rd1(9);
        chk("br_c1_flush", o_fl, 1);
        chk("br_c1_issue", o_is, 0);
        rd1(9);
        chk("br_c2_flush", o_fl, 0);
        chk("br_squash_stall", o_st, 0);
        chk("br_squash_issue", o_is, 1);

        // 4. back-to-back branches
        for (int k = 0; k < 4; k++) idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); chk("b2b_t0", o_fl, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); chk("b2b_t1", o_fl, 1);
        idle(1);                            chk("b2b_t2", o_fl, 1);
        idle(1);                            chk("b2b_t3", o_fl, 0);

        // 5. read/write same register; hazard coinciding with branch
        step(1, 1, 7, 1, 0, 0, 7, 1, 0, 1);
        chk("self_stall", o_st, 0);
        chk("self_issue", o_is, 1);
        rd1(7); chk("self_next_stall", o_st, 1);
        for (int k = 0; k < 4; k++) idle(1);
        wr(3);
        cnt0 = m_cnt;
        step(1, 1, 3, 1, 0, 0, 0, 0, 1, 1);
        chk("hzbr_flush", o_fl, 1);
        chk("hzbr_stall", o_st, 0);
        idle(1);
        chk("hzbr_cnt_hold", o_cnt, cnt0);

        // randomized traffic, decode holds its instruction while stalled
        for (int k = 0; k < 4; k++) idle(1);
        hold_v = 0; hold_rs1 = 0; hold_rs2 = 0; hold_rd = 0;
        hold_u1 = 0; hold_u2 = 0; hold_w = 0;
        for (int k = 0; k < 300; k++) begin
            if (o_st == 0) begin
                hold_v   = ($urandom_range(3) != 0);
                hold_rs1 = $urandom_range(7);
                hold_rs2 = $urandom_range(7);
                hold_rd  = $urandom_range(7);
                hold_u1  = 1'($urandom);
                hold_u2  = 1'($urandom);
                hold_w   = 1'($urandom);
            end
            step(1, hold_v, hold_rs1, hold_u1, hold_rs2, hold_u2, hold_rd, hold_w,
                 ($urandom_range(9) == 0), 1);
        end

        // 6. saturation and reset mid-flush
        idle(0);
        for (int k = 0; k < 12; k++) raw_seq(11);
        chk("sat_cnt", o_cnt, CNT_MAX);
        rd1(0);
        chk("sat_hold", o_cnt, CNT_MAX);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 2, 1, 0, 0, 0, 0, 0, 1);
        chk("midrst_flush_during", o_fl, 1);
        idle(1);
        chk("midrst_flush", o_fl, 0);
        chk("midrst_stall", o_st, 0);
        chk("midrst_cnt", o_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
